instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  - Instruction fetch stage, directly downstream of the program counter.
//  - Samples current_pc, issues one word read on the instruction-memory bus, and
//    captures the returned word. Presents {instr, instr_pc} to decode via a
//    valid/ready handshake.
//  - Returns a one-cycle pc_advance pulse that drives the PC increment op.
// PARAMETERS
//  XLEN            32            address/data width
//  NOP_INSTR       32'h00000013  instr value at reset and on error (addi x0,x0,0)
//  TIMEOUT_CYCLES  16            bus watchdog limit, used only with IFETCH_TIMEOUT_EN
// PORTS
//  sys_clk      in   1     clock; all flops update on posedge
//  sys_rst      in   1     reset, asynchronous, active-high
//  pc_in        in   XLEN  current_pc from PC stage
//  fetch_start  in   1     request fetch of pc_in
//  flush        in   1     discard in-flight/held fetch (branch/jump redirect)
//  imem_req     out  1     bus request
//  imem_addr    out  XLEN  bus word address
//  imem_ack     in   1     bus response strobe, 1 cycle, rdata valid with it
//  imem_rdata   in   XLEN  bus read data
//  instr        out  XLEN  fetched instruction
//  instr_pc     out  XLEN  address of instr
//  instr_valid  out  1     instr/instr_pc/fetch_err valid
//  instr_ready  in   1     decode accepts
//  fetch_err    out  1     misaligned (or, with IFETCH_TIMEOUT_EN, timed-out) fetch
//  pc_advance   out  1     1-cycle pulse to PC op input
//  busy         out  1     state != IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE, imem_req=0, imem_addr=0, instr=NOP_INSTR, instr_pc=0,
//    instr_valid=0, fetch_err=0, pc_advance=0. Asserting sys_rst mid-fetch aborts it;
//    a late ack after reset release is ignored in IDLE.
//  - States: IDLE, REQ, DRAIN, VALID. All outputs are registered.
//  - IDLE, fetch_start=1, pc_in[1:0]==0 -> REQ: imem_addr<=pc_in, imem_req<=1 next cycle.
//  - IDLE, fetch_start=1, pc_in[1:0]!=0 -> VALID: no bus cycle; fetch_err=1,
//    instr=NOP_INSTR, instr_pc=pc_in, pc_advance pulses.
//  - REQ: imem_req and imem_addr held stable until imem_ack; a request is never withdrawn.
//    On ack -> VALID: instr<=imem_rdata, instr_pc<=imem_addr, imem_req<=0,
//    instr_valid<=1, pc_advance=1 for that one cycle.
//  - Latency: fetch_start to instr_valid = 1 + bus wait cycles + 1; minimum 2 with a
//    same-cycle ack.
//  - VALID: outputs held while instr_ready=0. On instr_ready=1: clear valid and go to
//    IDLE; if fetch_start is also 1, take the new fetch back-to-back as from IDLE.
//  - flush in REQ -> DRAIN: req stays high until ack, data dropped, no pc_advance, -> IDLE.
//  - flush in VALID -> IDLE: instr_valid=0 next cycle.
//  - flush in IDLE or DRAIN: no effect.
//  - flush has priority over fetch_start and instr_ready in the same cycle.
//  - imem_ack outside REQ/DRAIN is ignored.
// CONFIGURATION
//  IFETCH_TIMEOUT_EN defined:
//   - Counter of wait cycles in REQ/DRAIN. Reaching TIMEOUT_CYCLES with no ack drops
//     req. From REQ -> VALID with fetch_err=1, instr=NOP_INSTR, pc_advance pulses.
//     From DRAIN -> IDLE.
//   - Counter clears on entry to REQ.
//  IFETCH_TIMEOUT_EN undefined:
//   - No counter; REQ/DRAIN wait indefinitely; fetch_err reports misalignment only.
// STRUCTURE
//  - ifetch_pkg: state enum (IDLE/REQ/DRAIN/VALID), NOP_INSTR default constant,
//    alignment-mask constant.
//  - Sub-module ifetch_watchdog: wait counter + timeout flag, instantiated only under
//    IFETCH_TIMEOUT_EN.
// TESTING
//  - Reset then fetch_start, pc_in=0x100, ack 3 cycles later with rdata=0x00500093
//    -> imem_addr=0x100, instr=0x00500093, instr_pc=0x100, single pc_advance.
//  - instr_ready held 0 for 4 cycles -> instr/instr_valid stable.
//  - instr_ready=1 with fetch_start, pc_in=0x104 -> req next cycle, no IDLE bubble.
//  - flush 1 cycle after req, ack with 0xDEADBEEF 2 cycles later -> req held to ack,
//    instr stays prior value, no instr_valid, no pc_advance, busy falls after ack.
//  - fetch_start, pc_in=0x102 -> no imem_req, fetch_err=1, instr=0x00000013, instr_pc=0x102.
//  - IFETCH_TIMEOUT_EN with no ack -> req drops after 16 wait cycles, fetch_err=1.
//  - sys_rst pulsed mid-REQ -> all outputs at reset values immediately (async).

Source files
------------

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - Shared state type and constants for the instruction fetch stage
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    VALID = 2'd3
  } ifetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [1:0]  ALIGN_MASK        = 2'b11;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_watchdog.sv
// rtl/ifetch_watchdog.sv - Bus wait-cycle counter; flags the cycle in which the wait limit is reached
module ifetch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic active_i,
  output logic timeout_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Fires on the TIMEOUT_CYCLES-th consecutive wait cycle, so the request is dropped on that edge.
  assign timeout_o = active_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (active_i && !timeout_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - Fetch stage: one imem word read per fetch_start, valid/ready hand-off to decode
// Optional bus watchdog enabled by defining IFETCH_TIMEOUT_EN.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] NOP_INSTR      = XLEN'(NOP_INSTR_DEFAULT),
  parameter int unsigned     TIMEOUT_CYCLES = 16
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            fetch_start,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            fetch_err,
  output logic            pc_advance,
  output logic            busy
);

  ifetch_state_e   state_q, state_d;
  logic            imem_req_q, imem_req_d;
  logic [XLEN-1:0] imem_addr_q, imem_addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic            fetch_err_q, fetch_err_d;
  logic            pc_advance_q, pc_advance_d;
  logic            take_fetch;
  logic            wdog_clear;
  logic            timeout;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

`ifdef IFETCH_TIMEOUT_EN
  ifetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (sys_clk),
    .rst_i    (sys_rst),
    .clear_i  (wdog_clear),
    .active_i ((state_q == REQ) || (state_q == DRAIN)),
    .timeout_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_err_d   = fetch_err_q;
    pc_advance_d  = 1'b0;
    take_fetch    = 1'b0;
    wdog_clear    = 1'b0;

    unique case (state_q)
      IDLE: begin
        take_fetch = fetch_start;
      end
      REQ: begin
        if (flush) begin
          // A flush coinciding with the bus completing needs no drain cycle.
          if (imem_ack || timeout) begin
            state_d    = IDLE;
            imem_req_d = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          state_d       = VALID;
          imem_req_d    = 1'b0;
          instr_d       = imem_rdata;
          instr_pc_d    = imem_addr_q;
          instr_valid_d = 1'b1;
          fetch_err_d   = 1'b0;
          pc_advance_d  = 1'b1;
        end else if (timeout) begin
          state_d       = VALID;
          imem_req_d    = 1'b0;
          instr_d       = NOP_INSTR;
          instr_pc_d    = imem_addr_q;
          instr_valid_d = 1'b1;
          fetch_err_d   = 1'b1;
          pc_advance_d  = 1'b1;
        end
      end
      DRAIN: begin
        if (imem_ack || timeout) begin
          state_d    = IDLE;
          imem_req_d = 1'b0;
        end
      end
      VALID: begin
        if (flush) begin
          state_d       = IDLE;
          instr_valid_d = 1'b0;
        end else if (instr_ready) begin
          state_d       = IDLE;
          instr_valid_d = 1'b0;
          take_fetch    = fetch_start;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take_fetch) begin
      if (is_word_aligned(pc_in[1:0])) begin
        state_d     = REQ;
        imem_req_d  = 1'b1;
        imem_addr_d = pc_in;
        wdog_clear  = 1'b1;
      end else begin
        state_d       = VALID;
        instr_d       = NOP_INSTR;
        instr_pc_d    = pc_in;
        instr_valid_d = 1'b1;
        fetch_err_d   = 1'b1;
        pc_advance_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      pc_advance_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
      pc_advance_q  <= pc_advance_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;
  assign pc_advance  = pc_advance_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - Self-checking bench for instr_fetch against a transaction-level model
module tb_instr_fetch;

  localparam int          TO  = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFETCH_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic        fetch_start = 1'b0;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        fetch_err;
  logic        pc_advance;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int adv_seen = 0;
  int req_cycles = 0;

  always #5 sys_clk = ~sys_clk;

  instr_fetch dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .pc_in      (pc_in),
    .fetch_start(fetch_start),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .fetch_err  (fetch_err),
    .pc_advance (pc_advance),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: at most one bus transaction open and at most one word held for decode.
  typedef struct {
    logic        open;
    logic [31:0] addr;
    logic        drop;
    int          waits;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
    logic        adv;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.open = 1'b0; r.addr = '0; r.drop = 1'b0; r.waits = 0;
    r.valid = 1'b0; r.instr = NOP; r.pc = '0; r.err = 1'b0; r.adv = 1'b0;
    return r;
  endfunction

  function automatic model_t model_next(input model_t c, input logic fs, input logic [31:0] pc,
                                        input logic fl, input logic ack, input logic [31:0] rd,
                                        input logic rdy);
    model_t n = c;
    logic can_start = 1'b0;
    n.adv = 1'b0;
    if (c.open) begin
      if (ack) begin
        n.open = 1'b0;
        if (!c.drop && !fl) begin
          n.valid = 1'b1; n.instr = rd; n.pc = c.addr; n.err = 1'b0; n.adv = 1'b1;
        end
      end else begin
        if (fl) n.drop = 1'b1;
        n.waits = c.waits + 1;
        if (TIMEOUT_EN && n.waits >= TO) begin
          n.open = 1'b0;
          if (!n.drop) begin
            n.valid = 1'b1; n.instr = NOP; n.pc = c.addr; n.err = 1'b1; n.adv = 1'b1;
          end
        end
      end
    end else if (c.valid) begin
      if (fl) n.valid = 1'b0;
      else if (rdy) begin
        n.valid = 1'b0;
        can_start = 1'b1;
      end
    end else begin
      can_start = 1'b1;
    end
    if (can_start && fs) begin
      if (pc % 4 != 0) begin
        n.valid = 1'b1; n.instr = NOP; n.pc = pc; n.err = 1'b1; n.adv = 1'b1;
      end else begin
        n.open = 1'b1; n.addr = pc; n.drop = 1'b0; n.waits = 0;
      end
    end
    return n;
  endfunction

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) m <= model_reset();
    else m <= model_next(m, fetch_start, pc_in, flush, imem_ack, imem_rdata, instr_ready);
  end

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, m.open});
      chk("imem_addr", imem_addr, m.addr);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m.valid});
      chk("pc_advance", {31'b0, pc_advance}, {31'b0, m.adv});
      chk("busy", {31'b0, busy}, {31'b0, m.open | m.valid});
      chk("instr", instr, m.instr);
      chk("instr_pc", instr_pc, m.pc);
      if (m.valid) chk("fetch_err", {31'b0, fetch_err}, {31'b0, m.err});
      if (pc_advance) adv_seen++;
      if (imem_req) req_cycles++;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_instr"}, instr, NOP);
    chk({tag, "_pc"}, instr_pc, 32'd0);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_err"}, {31'b0, fetch_err}, 32'd0);
    chk({tag, "_adv"}, {31'b0, pc_advance}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    repeat (2) tick();
    chk_reset_outputs("rst");
    sys_rst = 1'b0;
    tick();

    // Aligned fetch, ack after two wait cycles
    fetch_start = 1'b1; pc_in = 32'h100;
    tick();
    fetch_start = 1'b0;
    tick(); tick();
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("t1_valid", {31'b0, instr_valid}, 32'd1);
    chk("t1_instr", instr, 32'h0050_0093);
    chk("t1_pc", instr_pc, 32'h100);
    chk("t1_addr", imem_addr, 32'h100);
    chk("t1_adv", {31'b0, pc_advance}, 32'd1);

    // Decode stalls for four cycles
    repeat (4) tick();
    chk("t2_valid", {31'b0, instr_valid}, 32'd1);
    chk("t2_instr", instr, 32'h0050_0093);
    chk("t2_adv_count", adv_seen, 32'd1);

    // Accept plus back-to-back fetch, same-cycle ack
    instr_ready = 1'b1; fetch_start = 1'b1; pc_in = 32'h104;
    tick();
    instr_ready = 1'b0; fetch_start = 1'b0;
    #1;
    chk("t3_req", {31'b0, imem_req}, 32'd1);
    chk("t3_addr", imem_addr, 32'h104);
    chk("t3_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h00A0_0113;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("t3_instr", instr, 32'h00A0_0113);
    chk("t3_ipc", instr_pc, 32'h104);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Flush while the request is outstanding
    fetch_start = 1'b1; pc_in = 32'h108;
    tick();
    fetch_start = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("t4_req_held", {31'b0, imem_req}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("t4_req", {31'b0, imem_req}, 32'd0);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    chk("t4_instr", instr, 32'h00A0_0113);
    chk("t4_adv_count", adv_seen, 32'd2);

    // Misaligned pc
    fetch_start = 1'b1; pc_in = 32'h102;
    tick();
    fetch_start = 1'b0;
    #1;
    chk("t5_req", {31'b0, imem_req}, 32'd0);
    chk("t5_err", {31'b0, fetch_err}, 32'd1);
    chk("t5_instr", instr, NOP);
    chk("t5_pc", instr_pc, 32'h102);
    chk("t5_valid", {31'b0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Flush beats ready and fetch_start while holding a word
    fetch_start = 1'b1; pc_in = 32'h10C;
    tick();
    fetch_start = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h00C0_0193;
    tick();
    imem_ack = 1'b0;
    flush = 1'b1; instr_ready = 1'b1; fetch_start = 1'b1; pc_in = 32'h110;
    tick();
    flush = 1'b0; instr_ready = 1'b0; fetch_start = 1'b0;
    #1;
    chk("t6_valid", {31'b0, instr_valid}, 32'd0);
    chk("t6_req", {31'b0, imem_req}, 32'd0);
    chk("t6_instr", instr, 32'h00C0_0193);

    // Stray ack while idle
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("t7_instr", instr, 32'h00C0_0193);
    chk("t7_busy", {31'b0, busy}, 32'd0);

    // Unanswered request
    fetch_start = 1'b1; pc_in = 32'h200;
    tick();
    fetch_start = 1'b0;
    req_cycles = 0;
`ifdef IFETCH_TIMEOUT_EN
    begin
      int n = 0;
      while (imem_req && n < 40) begin
        tick();
        n++;
      end
      chk("t8_bounded", {31'b0, imem_req}, 32'd0);
      #4;
      chk("t8_req_cycles", req_cycles, TO);
      chk("t8_err", {31'b0, fetch_err}, 32'd1);
      chk("t8_instr", instr, NOP);
      chk("t8_pc", instr_pc, 32'h200);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
    end
`else
    repeat (20) tick();
    chk("t8_req_waits", {31'b0, imem_req}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("t8_busy", {31'b0, busy}, 32'd0);
`endif

    // Asynchronous reset mid-request, then a late ack
    fetch_start = 1'b1; pc_in = 32'h300;
    tick();
    fetch_start = 1'b0;
    #1;
    chk("t9_req", {31'b0, imem_req}, 32'd1);
    sys_rst = 1'b1;
    #1;
    chk_reset_outputs("arst");
    tick();
    sys_rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h0000_0BAD;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("t9_valid", {31'b0, instr_valid}, 32'd0);
    chk("t9_instr", instr, NOP);
    chk("t9_busy", {31'b0, busy}, 32'd0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
